// File: rtl/ast_det.sv
// ast_det: threshold/debounce detector ahead of the alarm sender.
// Qualifies over-threshold AD samples with hysteresis (th_hi arms, th_lo
// releases), a consecutive-sample debounce and a microsecond holdoff, then
// emits a one-cycle trig pulse and a stu_sensor status byte.
// Optional feature macro: AST_DET_PEAK_EN (peak-sample tracking). When it is
// undefined, peak is tied to zero and no peak logic exists.
module ast_det #(
  parameter int DW = 16,
  parameter int CW = 8,
  parameter int HW = 16
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          pluse_us,
  input  logic [DW-1:0] ad_data,
  input  logic          ad_vld,
  input  logic          cfg_en,
  input  logic [DW-1:0] cfg_th_hi,
  input  logic [DW-1:0] cfg_th_lo,
  input  logic [CW-1:0] cfg_cnt,
  input  logic [HW-1:0] cfg_hold,
  input  logic          stu_clr,
  output logic          trig,
  output logic [7:0]    stu_sensor,
  output logic [DW-1:0] peak
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_ACTIVE = 3'd2,
    S_DEARM  = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_nx;
  logic [CW-1:0] dcnt_r;
  logic [CW-1:0] dcnt_nx;
  logic [HW-1:0] hcnt_r;
  logic [HW-1:0] hcnt_nx;
  logic          trig_nx;
  logic          trig_r;
  logic          level_r;
  logic          hold_r;
  logic          stick_trig_r;
  logic          stick_drop_r;
  logic [3:0]    tcnt_r;

  logic [CW-1:0] cnt_eff;
  logic          cnt_one;
  logic [CW:0]   dcnt_inc;
  logic          dcnt_done;
  logic          hi_hit;
  logic          lo_hit;
  logic          drop_ev;

  // Saturating increment of the debounce counter (never wraps).
  function automatic logic [CW-1:0] dcnt_sat(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  // Saturating increment of the holdoff counter (never wraps).
  function automatic logic [HW-1:0] hcnt_sat(input logic [HW-1:0] v);
    return (v == {HW{1'b1}}) ? v : v + {{(HW-1){1'b0}}, 1'b1};
  endfunction

  // Compare terms: a debounce length of 0 behaves as 1; thresholds are
  // evaluated independently so an inverted pair needs no special case.
  always_comb begin
    cnt_eff   = (cfg_cnt == {CW{1'b0}}) ? {{(CW-1){1'b0}}, 1'b1} : cfg_cnt;
    cnt_one   = (cnt_eff == {{(CW-1){1'b0}}, 1'b1});
    dcnt_inc  = {1'b0, dcnt_r} + {{CW{1'b0}}, 1'b1};
    dcnt_done = (dcnt_inc >= {1'b0, cnt_eff});
    hi_hit    = ad_vld && (ad_data >= cfg_th_hi);
    lo_hit    = ad_vld && (ad_data <= cfg_th_lo);
    drop_ev   = ad_vld && (state_r == S_HOLD);
  end

  // Next-state, counter and trig decode of the detector FSM.
  always_comb begin
    state_nx = state_r;
    dcnt_nx  = dcnt_r;
    hcnt_nx  = hcnt_r;
    trig_nx  = 1'b0;
    if (!cfg_en) begin
      state_nx = S_IDLE;
      dcnt_nx  = {CW{1'b0}};
      hcnt_nx  = {HW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (hi_hit) begin
            if (cnt_one) begin
              state_nx = S_ACTIVE;
              dcnt_nx  = {CW{1'b0}};
              trig_nx  = 1'b1;
            end else begin
              state_nx = S_ARM;
              dcnt_nx  = {{(CW-1){1'b0}}, 1'b1};
            end
          end else begin
            dcnt_nx = {CW{1'b0}};
          end
        end
        S_ARM: begin
          if (hi_hit) begin
            if (dcnt_done) begin
              state_nx = S_ACTIVE;
              dcnt_nx  = {CW{1'b0}};
              trig_nx  = 1'b1;
            end else begin
              dcnt_nx = dcnt_sat(dcnt_r);
            end
          end else if (ad_vld) begin
            state_nx = S_IDLE;
            dcnt_nx  = {CW{1'b0}};
          end else begin
            dcnt_nx = dcnt_r;
          end
        end
        S_ACTIVE: begin
          if (lo_hit) begin
            if (cnt_one) begin
              state_nx = S_HOLD;
              dcnt_nx  = {CW{1'b0}};
              hcnt_nx  = {HW{1'b0}};
            end else begin
              state_nx = S_DEARM;
              dcnt_nx  = {{(CW-1){1'b0}}, 1'b1};
            end
          end else begin
            dcnt_nx = dcnt_r;
          end
        end
        S_DEARM: begin
          if (lo_hit) begin
            if (dcnt_done) begin
              state_nx = S_HOLD;
              dcnt_nx  = {CW{1'b0}};
              hcnt_nx  = {HW{1'b0}};
            end else begin
              dcnt_nx = dcnt_sat(dcnt_r);
            end
          end else if (ad_vld) begin
            state_nx = S_ACTIVE;
            dcnt_nx  = {CW{1'b0}};
          end else begin
            dcnt_nx = dcnt_r;
          end
        end
        S_HOLD: begin
          if (hcnt_r == cfg_hold) begin
            state_nx = S_IDLE;
            hcnt_nx  = {HW{1'b0}};
          end else if (pluse_us) begin
            hcnt_nx = hcnt_sat(hcnt_r);
          end else begin
            hcnt_nx = hcnt_r;
          end
        end
        default: begin
          state_nx = S_IDLE;
          dcnt_nx  = {CW{1'b0}};
          hcnt_nx  = {HW{1'b0}};
        end
      endcase
    end
  end

  // State, counters, trig pulse and status fields; a set of a sticky bit or
  // the trig count wins over a coincident stu_clr.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_r      <= S_IDLE;
      dcnt_r       <= {CW{1'b0}};
      hcnt_r       <= {HW{1'b0}};
      trig_r       <= 1'b0;
      level_r      <= 1'b0;
      hold_r       <= 1'b0;
      stick_trig_r <= 1'b0;
      stick_drop_r <= 1'b0;
      tcnt_r       <= 4'd0;
    end else begin
      state_r      <= state_nx;
      dcnt_r       <= dcnt_nx;
      hcnt_r       <= hcnt_nx;
      trig_r       <= trig_nx;
      level_r      <= (state_nx == S_ACTIVE) || (state_nx == S_DEARM);
      hold_r       <= (state_nx == S_HOLD);
      stick_trig_r <= trig_nx || (stick_trig_r && !stu_clr);
      stick_drop_r <= drop_ev || (stick_drop_r && !stu_clr);
      if (trig_nx) begin
        tcnt_r <= stu_clr ? 4'd1 : tcnt_r + 4'd1;
      end else if (stu_clr) begin
        tcnt_r <= 4'd0;
      end else begin
        tcnt_r <= tcnt_r;
      end
    end
  end

  assign trig       = trig_r;
  assign stu_sensor = {tcnt_r, hold_r, stick_drop_r, stick_trig_r, level_r};

`ifdef AST_DET_PEAK_EN
  logic [DW-1:0] peak_r;
  logic          peak_trk;

  // Peak tracking is live only while an event is arming, active or releasing.
  always_comb begin
    peak_trk = cfg_en && ad_vld &&
               ((state_r == S_ARM) || (state_r == S_ACTIVE) || (state_r == S_DEARM));
  end

  // Peak restarts at the first arming sample and is frozen in HOLD/IDLE.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      peak_r <= {DW{1'b0}};
    end else if (cfg_en && (state_r == S_IDLE) && hi_hit) begin
      peak_r <= ad_data;
    end else if (peak_trk && (ad_data > peak_r)) begin
      peak_r <= ad_data;
    end else begin
      peak_r <= peak_r;
    end
  end

  assign peak = peak_r;
`else
  assign peak = {DW{1'b0}};
`endif

endmodule

// File: tb/tb_ast_det.sv
// tb_ast_det: directed scenarios plus randomized traffic, every cycle checked
// against a behavioural model of the detector rules.
module tb_ast_det;
  localparam int DW = 16;
  localparam int CW = 8;
  localparam int HW = 16;
`ifdef AST_DET_PEAK_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  logic          clk_sys = 1'b0;
  logic          rst;
  logic          pluse_us;
  logic [DW-1:0] ad_data;
  logic          ad_vld;
  logic          cfg_en;
  logic [DW-1:0] cfg_th_hi;
  logic [DW-1:0] cfg_th_lo;
  logic [CW-1:0] cfg_cnt;
  logic [HW-1:0] cfg_hold;
  logic          stu_clr;
  logic          trig;
  logic [7:0]    stu_sensor;
  logic [DW-1:0] peak;

  int errors = 0;
  int checks = 0;
  int ntrig;

  // model: mode 0 idle, 1 arming, 2 active, 3 releasing, 4 holdoff
  int m_mode, m_run, m_us, m_tc, m_peak;
  bit m_trig, m_st_t, m_st_d;

  always #5 clk_sys = ~clk_sys;

  ast_det #(.DW(DW), .CW(CW), .HW(HW)) dut (
    .clk_sys(clk_sys), .rst(rst), .pluse_us(pluse_us), .ad_data(ad_data),
    .ad_vld(ad_vld), .cfg_en(cfg_en), .cfg_th_hi(cfg_th_hi), .cfg_th_lo(cfg_th_lo),
    .cfg_cnt(cfg_cnt), .cfg_hold(cfg_hold), .stu_clr(stu_clr), .trig(trig),
    .stu_sensor(stu_sensor), .peak(peak)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // What the registers must hold after the coming edge, from the detector rules.
  task automatic model_step();
    int s, eff;
    bit hi, lo, t, drop;
    s    = int'(ad_data);
    eff  = (cfg_cnt == 0) ? 1 : int'(cfg_cnt);
    hi   = ad_vld && (ad_data >= cfg_th_hi);
    lo   = ad_vld && (ad_data <= cfg_th_lo);
    drop = ad_vld && (m_mode == 4);
    t    = 1'b0;
    if (rst) begin
      m_mode = 0; m_run = 0; m_us = 0; m_trig = 0;
      m_st_t = 0; m_st_d = 0; m_tc = 0; m_peak = 0;
      return;
    end
    if (!cfg_en) begin
      m_mode = 0; m_run = 0; m_us = 0;
    end else begin
      if (ad_vld && (m_mode >= 1) && (m_mode <= 3) && (s > m_peak)) m_peak = s;
      case (m_mode)
        0: if (hi) begin
          m_peak = s;
          m_run  = 1;
          if (eff == 1) begin m_mode = 2; m_run = 0; t = 1; end
          else m_mode = 1;
        end
        1: if (hi) begin
          m_run++;
          if (m_run >= eff) begin m_mode = 2; m_run = 0; t = 1; end
        end else if (ad_vld) begin
          m_mode = 0; m_run = 0;
        end
        2: if (lo) begin
          if (eff == 1) begin m_mode = 4; m_us = 0; m_run = 0; end
          else begin m_mode = 3; m_run = 1; end
        end
        3: if (lo) begin
          m_run++;
          if (m_run >= eff) begin m_mode = 4; m_us = 0; m_run = 0; end
        end else if (ad_vld) begin
          m_mode = 2; m_run = 0;
        end
        4: if (m_us == int'(cfg_hold)) begin
          m_mode = 0; m_us = 0;
        end else if (pluse_us) begin
          m_us++;
        end
        default: m_mode = 0;
      endcase
    end
    m_trig = t;
    if (stu_clr) begin m_st_t = 0; m_st_d = 0; m_tc = 0; end
    if (t) begin m_st_t = 1; m_tc = (m_tc + 1) % 16; end
    if (drop) m_st_d = 1;
  endtask

  // One clock: advance the model, then compare all outputs after the edge.
  task automatic cyc();
    logic [7:0] exp_st;
    model_step();
    @(posedge clk_sys);
    #1;
    exp_st = {m_tc[3:0], (m_mode == 4), m_st_d, m_st_t, (m_mode == 2 || m_mode == 3)};
    chk("trig", {31'd0, trig}, {31'd0, m_trig});
    chk("stu_sensor", {24'd0, stu_sensor}, {24'd0, exp_st});
    chk("peak", {16'd0, peak}, PEAK_ON ? m_peak : 32'd0);
    if (trig === 1'b1) ntrig++;
  endtask

  task automatic smp(input int v);
    ad_vld  = 1'b1;
    ad_data = v[DW-1:0];
    cyc();
    ad_vld  = 1'b0;
  endtask

  task automatic hold_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      pluse_us = 1'b1; cyc();
      pluse_us = 1'b0; cyc();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pluse_us = 1'b0; ad_data = 16'd0; ad_vld = 1'b0; cfg_en = 1'b1;
    cfg_th_hi = 16'd1000; cfg_th_lo = 16'd800; cfg_cnt = 8'd3; cfg_hold = 16'd5;
    stu_clr = 1'b0; ntrig = 0;
    m_mode = 0; m_run = 0; m_us = 0; m_tc = 0; m_peak = 0;
    m_trig = 0; m_st_t = 0; m_st_d = 0;

    // reset state
    cyc();
    rst = 1'b0;
    chk("reset_status", {24'd0, stu_sensor}, 32'h00);
    chk("reset_trig", {31'd0, trig}, 32'd0);

    // arm after three consecutive >= th_hi samples
    smp(900); smp(1000); smp(1100); smp(1200);
    chk("arm_trig", {31'd0, trig}, 32'd1);
    chk("arm_status", {24'd0, stu_sensor}, 32'h13);
    cyc();
    chk("trig_one_cycle", {31'd0, trig}, 32'd0);

    // release aborted by 900, then three <= th_lo samples enter holdoff
    smp(700); smp(900); smp(700); smp(700); smp(700);
    chk("hold_entered", {31'd0, stu_sensor[3]}, 32'd1);
    chk("level_off_in_hold", {31'd0, stu_sensor[0]}, 32'd0);
    smp(100);
    chk("drop_sticky", {31'd0, stu_sensor[2]}, 32'd1);
    hold_pulses(4);
    chk("hold_after_4us", {31'd0, stu_sensor[3]}, 32'd1);
    hold_pulses(1);
    chk("idle_after_5us", {31'd0, stu_sensor[3]}, 32'd0);

    // short excursion does not trigger
    ntrig = 0;
    smp(1000); smp(1100); smp(500);
    chk("abort_level", {31'd0, stu_sensor[0]}, 32'd0);
    chk("abort_no_trig", ntrig, 32'd0);

    // single-sample debounce, zero holdoff, trig-count wrap
    cfg_cnt = 8'd0; cfg_hold = 16'd0;
    stu_clr = 1'b1; cyc(); stu_clr = 1'b0;
    ntrig = 0;
    for (int e = 0; e < 17; e++) begin
      smp(1200); smp(100); cyc();
    end
    chk("trig_pulses_17", ntrig, 32'd17);
    chk("tcnt_wrap", {28'd0, stu_sensor[7:4]}, 32'd1);
    smp(1200); smp(100); cyc();
    chk("tcnt_two", {28'd0, stu_sensor[7:4]}, 32'd2);
    stu_clr = 1'b1; smp(1200); stu_clr = 1'b0;
    chk("clr_vs_trig_cnt", {28'd0, stu_sensor[7:4]}, 32'd1);
    chk("clr_vs_trig_sticky", {31'd0, stu_sensor[1]}, 32'd1);

    // enable dropped mid-arm restarts debounce; rst in ACTIVE clears outputs
    cfg_cnt = 8'd3; do_reset();
    ntrig = 0;
    smp(1000); smp(1000);
    cfg_en = 1'b0; cyc(); cfg_en = 1'b1;
    smp(1000); smp(1000);
    chk("en_drop_no_trig", ntrig, 32'd0);
    smp(1000);
    chk("en_restore_trig", {31'd0, trig}, 32'd1);
    do_reset();
    chk("rst_status", {24'd0, stu_sensor}, 32'h00);
    chk("rst_trig", {31'd0, trig}, 32'd0);
    chk("rst_peak", {16'd0, peak}, 32'd0);

    // peak capture and hold through holdoff and idle
    cfg_hold = 16'd5;
    smp(1000); smp(1500); smp(1200);
    smp(700); smp(700); smp(700);
    chk("peak_in_hold", {16'd0, peak}, PEAK_ON ? 32'd1500 : 32'd0);
    hold_pulses(5);
    smp(900);
    chk("peak_in_idle", {16'd0, peak}, PEAK_ON ? 32'd1500 : 32'd0);

    // randomized traffic, fresh configuration per segment
    for (int seg = 0; seg < 20; seg++) begin
      cfg_th_hi = 16'($urandom_range(300, 700));
      cfg_th_lo = 16'($urandom_range(100, 750));
      cfg_cnt   = 8'($urandom_range(0, 4));
      cfg_hold  = 16'($urandom_range(0, 6));
      cfg_en    = 1'b1;
      do_reset();
      for (int c = 0; c < 400; c++) begin
        ad_vld   = ($urandom_range(0, 1) == 1);
        ad_data  = 16'($urandom_range(0, 1023));
        pluse_us = ($urandom_range(0, 3) == 0);
        cfg_en   = ($urandom_range(0, 39) != 0);
        stu_clr  = ($urandom_range(0, 19) == 0);
        rst      = ($urandom_range(0, 299) == 0);
        cyc();
      end
      rst = 1'b0; ad_vld = 1'b0; pluse_us = 1'b0; stu_clr = 1'b0; cfg_en = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ast_det.md
Name: ast_det

Overview:
- Threshold/debounce detector that sits directly upstream of the alarm sender.
- Consumes the raw 16-bit AD sample stream (ad_data/ad_vld) and qualifies over-threshold events with hysteresis, a consecutive-sample debounce and a microsecond holdoff.
- Emits a one-cycle trig pulse that drives the alarm-send path.
- Produces the stu_sensor status byte read back through the register block.

Parameters:
- DW, 16, AD sample width (unsigned).
- CW, 8, debounce counter width.
- HW, 16, holdoff counter width, in microseconds.

Ports:
- clk_sys  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pluse_us  in  1  one-cycle strobe every 1 us
- ad_data  in  DW  AD sample, unsigned
- ad_vld  in  1  sample valid, one cycle per sample
- cfg_en  in  1  detector enable
- cfg_th_hi  in  DW  arm threshold (sample >= th_hi counts)
- cfg_th_lo  in  DW  release threshold (sample <= th_lo counts)
- cfg_cnt  in  CW  consecutive samples required to arm/release; 0 treated as 1
- cfg_hold  in  HW  holdoff after release, in us
- stu_clr  in  1  one-cycle clear of sticky status/count
- trig  out  1  one-cycle detection pulse
- stu_sensor  out  8  status byte
- peak  out  DW  peak sample of last event (optional feature)

Interface decision: one clock (clk_sys); reset is synchronous and active-high (rst).

Behaviour:
- Reset (rst=1 at a clk_sys edge):
  - State=IDLE; all counters=0.
  - trig=0, stu_sensor=8'h00, peak=0.
- Only cycles with ad_vld=1 advance the debounce counters. Non-vld cycles hold them.
- States:
  - IDLE:
    - vld and sample>=th_hi: dcnt=1; if cfg_cnt<=1 go ACTIVE, else go ARM.
  - ARM:
    - vld and sample>=th_hi: dcnt++; on dcnt+1==max(cfg_cnt,1) go ACTIVE.
    - vld and sample<th_hi: go IDLE, dcnt=0.
  - ACTIVE:
    - trig=1 for exactly the single cycle after the qualifying vld (latency 1 clk from the completing sample).
    - vld and sample<=th_lo: start release count (same rule as ARM), go DEARM, or go straight to HOLD if cfg_cnt<=1.
  - DEARM:
    - vld and sample<=th_lo: dcnt++; on reaching cfg_cnt go HOLD.
    - vld and sample>th_lo: back to ACTIVE, dcnt=0, no new trig.
  - HOLD:
    - Samples ignored. hcnt increments on pluse_us.
    - hcnt==cfg_hold: go IDLE.
    - cfg_hold=0: HOLD lasts exactly one cycle, then IDLE.
- Counter widths: dcnt saturates at 2^CW-1; hcnt saturates at 2^HW-1. Neither wraps.
- Threshold inversion: if th_lo>=th_hi, comparisons are still applied independently. A sample can satisfy both, and behaviour remains the FSM above with no special case.
- cfg_en=0 in any state: next cycle forces IDLE, counters=0, no trig. A trig already driven in that cycle completes.
- stu_sensor fields:
  - [0] level: 1 in ACTIVE or DEARM.
  - [1] sticky: set on trig.
  - [2] sticky: set if ad_vld arrives during HOLD (sample dropped).
  - [3] state==HOLD.
  - [7:4] trig count, mod 16 (wraps 15->0).
- stu_clr clears [2:1] and [7:4] next cycle. On the same cycle as a trig, the set wins: [1]=1, count=1.
- Config changes mid-event take effect on the next vld compare; no restart.

Optional Feature:
- Macro: AST_DET_PEAK_EN.
- Defined:
  - peak register tracks max(sample) across ARM/ACTIVE/DEARM.
  - Reset to the first arming sample on entry to ARM (or ACTIVE when cfg_cnt<=1).
  - Frozen in HOLD/IDLE until the next arm.
  - stu_clr does not clear peak.
- Undefined: peak tied to 0 and no peak logic instantiated.

Test Plan:
- th_hi=1000, th_lo=800, cfg_cnt=3, cfg_hold=5; samples 900, 1000, 1100, 1200 -> single trig one clk after the 1200 vld; stu_sensor=8'h13.
- Same config; samples 1000, 1100, 500 -> no trig, state returns IDLE, stu_sensor[0]=0.
- Event active; samples 700, 900, 700, 700, 700 -> DEARM aborts on 900; HOLD entered after the third consecutive <=800; IDLE exactly 5 pluse_us later; ad_vld during HOLD sets stu_sensor[2].
- cfg_cnt=0, cfg_hold=0; 17 separate events -> 17 trig pulses, stu_sensor[7:4]=1; stu_clr coincident with a trig -> [7:4]=1, [1]=1.
- cfg_en dropped in ARM with dcnt=2, then restored -> no trig; the next arming requires the full 3 samples. rst asserted in ACTIVE -> all outputs 0 on the next clk.
- AST_DET_PEAK_EN defined; event samples 1000, 1500, 1200, then release -> peak=1500, held through HOLD/IDLE; undefined build -> peak=0.
